video_path_ctrl: RTL and testbench
==================================

VIDEO_PATH_CTRL -- requirements
Module: video_path_ctrl

Interface
REQ-001 Parameter: LATENCY, default 10, pipeline latency in clk cycles of the attached rgb2hsv converter; legal range 1..32.
REQ-002 Parameter: CNT_W, default 12, width of the pixel and line counters.
REQ-003 clk  in  1  pixel clock; one clock for the whole block.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_de, in_hsync, in_vsync  in  1 each  source video timing; vsync active-high.
REQ-006 in_rgb  in  24  source pixel {R,G,B}.
REQ-007 proc_de, proc_hsync, proc_vsync  in  1 each  timing returned by the converter.
REQ-008 proc_data  in  24  converter output {H,S,V}.
REQ-009 conv_ce  out  1  clock enable driven to the converter.
REQ-010 mode_req  in  2  requested mode: 0 bypass RGB, 1 HSV, 2 black, 3 reserved.
REQ-011 mode_req_valid / mode_req_ready  in / out  1 each  request handshake.
REQ-012 mode_active  out  2  mode currently applied to the output.
REQ-013 out_de, out_hsync, out_vsync  out  1 each  output timing.
REQ-014 out_data  out  24  output pixel.
REQ-015 pix_cnt, line_cnt  out  CNT_W each  active pixels per line and active lines per frame from the last complete frame.
REQ-016 frame_done  out  1  one-cycle pulse at each frame start after the first.

Function
REQ-017 Frame start (fs) SHALL be the rising edge of in_vsync, detected against a registered copy.
REQ-018 FSM states IDLE, RUN, PEND; IDLE->RUN on first fs; RUN->PEND on accepted request; PEND->RUN on next fs, applying the pending mode in that cycle.
REQ-019 mode_req_ready SHALL be 1 only in RUN; request accepted when valid and ready are both 1 in the same cycle.
REQ-020 Request with mode_req=3 SHALL be accepted and discarded (state stays RUN, mode_active unchanged).
REQ-021 In IDLE mode_active SHALL be 0 and mode_req_ready 0.
REQ-022 A bypass path SHALL delay in_rgb and in_de/hsync/vsync by exactly LATENCY cycles via a shift register.
REQ-023 Output SHALL be registered: mode 0 selects bypass path, mode 1 selects proc_* signals, mode 2 selects bypass timing with out_data forced to 0; total input-to-output latency LATENCY+1 cycles for every mode.
REQ-024 The mode select used by the output mux SHALL be mode_active delayed LATENCY cycles so that a switch lands exactly on the delayed frame boundary.
REQ-025 conv_ce SHALL be 1 whenever the state is not IDLE, or when the delayed mode select is 1; otherwise 0.
REQ-026 fs coincident with an accepted request in RUN: the request SHALL NOT apply at that fs; it applies at the following fs.
REQ-027 Loss of video (no fs for 2^(2*CNT_W) cycles, counter saturating) SHALL return FSM to IDLE and discard any pending mode.

Reset
REQ-028 On rst_n low, asynchronously: FSM IDLE, mode_active 0, mode_req_ready 0, conv_ce 0, all out_* 0, shift registers 0, pix_cnt/line_cnt 0, frame_done 0.
REQ-029 Reset asserted in PEND SHALL discard the pending mode; after release operation resumes from IDLE.

Configuration
REQ-030 Macro VIDEO_PATH_CTRL_STATS_EN: when defined, pix_cnt counts in_de-high cycles of the first active line of each frame, line_cnt counts in_de rising edges per frame, both latched at fs, frame_done pulses at each fs in RUN/PEND, counters saturate at all-ones.
REQ-031 Without VIDEO_PATH_CTRL_STATS_EN, pix_cnt, line_cnt and frame_done SHALL be tied to 0 and no counter logic instantiated.

Verification
REQ-032 Reset then 64x4 active frame at LATENCY=10, mode 0 -> out_data equals in_rgb delayed 11 cycles, out_vsync aligned to in_vsync+11.
REQ-033 Request mode 1 mid-frame -> ready drops next cycle, mode_active stays 0 until next fs, then 1; first HSV pixel at output is pixel 0 of that frame, no mixed-mode frame.
REQ-034 Request mode 2 in the same cycle as fs -> mode_active changes only at the subsequent fs; out_data 0 while out_de toggles normally.
REQ-035 Request mode 3 -> accepted, mode_active unchanged, ready returns 1 next cycle.
REQ-036 STATS_EN defined, 64x4 frame -> after second fs pix_cnt=64, line_cnt=4, frame_done one-cycle pulse; undefined -> all 0.
REQ-037 rst_n pulsed low while in PEND -> all outputs 0 immediately; after release mode_active 0 and first fs returns to RUN.

Source files
------------

// File: rtl/video_path_ctrl.sv
// rtl/video_path_ctrl.sv - video output path with frame-synchronous mode switching
// Optional frame statistics are enabled with `define VIDEO_PATH_CTRL_STATS_EN.
module video_path_ctrl #(
  parameter int LATENCY = 10,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_de,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic [23:0]      in_rgb,
  input  logic             proc_de,
  input  logic             proc_hsync,
  input  logic             proc_vsync,
  input  logic [23:0]      proc_data,
  output logic             conv_ce,
  input  logic [1:0]       mode_req,
  input  logic             mode_req_valid,
  output logic             mode_req_ready,
  output logic [1:0]       mode_active,
  output logic             out_de,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [23:0]      out_data,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam int LOV_W = 2 * CNT_W;

  state_t             state, state_nxt;
  logic [1:0]         pend_mode, pend_nxt, mode_nxt;
  logic               vsync_q;
  logic               fs;
  logic [LOV_W-1:0]   lov_cnt;
  logic               lov;

  logic [23:0]        rgb_d  [LATENCY];
  logic [1:0]         mode_d [LATENCY];
  logic [LATENCY-1:0] de_d, hs_d, vs_d;
  logic [1:0]         mode_sel;

  assign fs             = in_vsync & ~vsync_q;
  assign lov            = &lov_cnt;
  assign mode_req_ready = (state == RUN);
  assign mode_sel       = mode_d[LATENCY-1];
  assign conv_ce        = (state != IDLE) || (mode_sel == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_active <= 2'd0;
      pend_mode   <= 2'd0;
      vsync_q     <= 1'b0;
      lov_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      mode_active <= mode_nxt;
      pend_mode   <= pend_nxt;
      vsync_q     <= in_vsync;
      lov_cnt     <= fs ? '0 : (lov ? lov_cnt : lov_cnt + 1'b1);
    end
  end

  // A request accepted in the fs cycle itself lands in PEND after that fs,
  // so it waits for the following frame start.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_active;
    pend_nxt  = pend_mode;
    case (state)
      IDLE: if (fs) state_nxt = RUN;
      RUN: begin
        if (mode_req_valid && mode_req != 2'd3) begin
          state_nxt = PEND;
          pend_nxt  = mode_req;
        end
      end
      PEND: begin
        if (fs) begin
          state_nxt = RUN;
          mode_nxt  = pend_mode;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && lov && !fs) begin
      state_nxt = IDLE;
      mode_nxt  = 2'd0;
      pend_nxt  = 2'd0;
    end
  end

  // mode_d[0] takes the next mode so the select travels alongside the pixel
  // sampled in the same cycle the switch is decided.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        rgb_d[i]  <= '0;
        mode_d[i] <= 2'd0;
      end
      de_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
    end else begin
      rgb_d[0]  <= in_rgb;
      mode_d[0] <= mode_nxt;
      de_d[0]   <= in_de;
      hs_d[0]   <= in_hsync;
      vs_d[0]   <= in_vsync;
      for (int i = 1; i < LATENCY; i++) begin
        rgb_d[i]  <= rgb_d[i-1];
        mode_d[i] <= mode_d[i-1];
        de_d[i]   <= de_d[i-1];
        hs_d[i]   <= hs_d[i-1];
        vs_d[i]   <= vs_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_data  <= '0;
    end else begin
      case (mode_sel)
        2'd1: begin
          out_de    <= proc_de;
          out_hsync <= proc_hsync;
          out_vsync <= proc_vsync;
          out_data  <= proc_data;
        end
        2'd2: begin
          out_de    <= de_d[LATENCY-1];
          out_hsync <= hs_d[LATENCY-1];
          out_vsync <= vs_d[LATENCY-1];
          out_data  <= '0;
        end
        default: begin
          out_de    <= de_d[LATENCY-1];
          out_hsync <= hs_d[LATENCY-1];
          out_vsync <= vs_d[LATENCY-1];
          out_data  <= rgb_d[LATENCY-1];
        end
      endcase
    end
  end

`ifdef VIDEO_PATH_CTRL_STATS_EN
  logic             de_q, fd_q;
  logic [CNT_W-1:0] pix_acc, line_acc, pix_q, line_q;
  logic [CNT_W-1:0] pix_base, line_base, pix_nxt, line_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  // Pixels are counted only while the line count reads one: the first active line.
  always_comb begin
    pix_base  = fs ? '0 : pix_acc;
    line_base = fs ? '0 : line_acc;
    line_nxt  = (in_de && !de_q) ? sat_inc(line_base) : line_base;
    pix_nxt   = (in_de && line_nxt == CNT_W'(1)) ? sat_inc(pix_base) : pix_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q     <= 1'b0;
      fd_q     <= 1'b0;
      pix_acc  <= '0;
      line_acc <= '0;
      pix_q    <= '0;
      line_q   <= '0;
    end else begin
      de_q     <= in_de;
      pix_acc  <= pix_nxt;
      line_acc <= line_nxt;
      fd_q     <= fs && (state != IDLE);
      if (fs && state != IDLE) begin
        pix_q  <= pix_acc;
        line_q <= line_acc;
      end
    end
  end

  assign pix_cnt    = pix_q;
  assign line_cnt   = line_q;
  assign frame_done = fd_q;
`else
  assign pix_cnt    = '0;
  assign line_cnt   = '0;
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_video_path_ctrl.sv
// tb/tb_video_path_ctrl.sv - self-checking bench for video_path_ctrl
// Frame-level reference model; stats expectations follow VIDEO_PATH_CTRL_STATS_EN.
module tb_video_path_ctrl;
  localparam int L = 10, CW = 12;
  localparam int HT = 76, VT = 7, HACT = 64, VACT = 4, FRAME = HT * VT;
`ifdef VIDEO_PATH_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_de, in_hsync, in_vsync, proc_de, proc_hsync, proc_vsync;
  logic [23:0] in_rgb, proc_data, out_data;
  logic conv_ce, mode_req_valid, mode_req_ready, out_de, out_hsync, out_vsync, frame_done;
  logic [1:0] mode_req, mode_active;
  logic [CW-1:0] pix_cnt, line_cnt;

  int checks, failures;

  video_path_ctrl #(.LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_rgb(in_rgb), .proc_de(proc_de), .proc_hsync(proc_hsync), .proc_vsync(proc_vsync),
    .proc_data(proc_data), .conv_ce(conv_ce), .mode_req(mode_req),
    .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
    .mode_active(mode_active), .out_de(out_de), .out_hsync(out_hsync),
    .out_vsync(out_vsync), .out_data(out_data), .pix_cnt(pix_cnt),
    .line_cnt(line_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Input history per sampled cycle, and the mode each sampled pixel belongs to.
  logic [23:0] h_rgb [64];
  logic        h_de [64], h_hs [64], h_vs [64];
  logic [1:0]  h_pm [64];
  int          n, gpos;
  bit          running, has_pend;
  logic [1:0]  active, pend_mode;
  logic [23:0] e_data;
  logic        e_de, e_hs, e_vs, e_ready, e_ce, e_fd;
  logic [CW-1:0] e_pix, e_line;

  function automatic logic [23:0] hsv_of(input logic [23:0] x);
    return {x[7:0], x[23:16] ^ 8'h5A, x[15:8] + 8'd3};
  endfunction

  task automatic model_reset();
    n = 0; running = 0; has_pend = 0; active = 2'd0; pend_mode = 2'd0;
    e_data = '0; {e_de, e_hs, e_vs, e_ready, e_ce, e_fd} = '0; e_pix = '0; e_line = '0;
  endtask

  task automatic zero_inputs();
    {in_de, in_hsync, in_vsync, proc_de, proc_hsync, proc_vsync, mode_req_valid} = '0;
    in_rgb = '0; proc_data = '0; mode_req = 2'd0;
  endtask

  task automatic step(input bit v, input logic [1:0] r);
    int line, col, k, j;
    bit fs, prev_vs;
    logic [1:0] pm;
    @(negedge clk);
    line = gpos / HT; col = gpos % HT;
    in_vsync = (line == 0); in_hsync = (col < 4);
    in_de = (line >= 2 && line < 2 + VACT && col >= HT - HACT);
    in_rgb = 24'($urandom);
    mode_req_valid = v; mode_req = r;
    h_rgb[n % 64] = in_rgb; h_de[n % 64] = in_de; h_hs[n % 64] = in_hsync; h_vs[n % 64] = in_vsync;
    k = n - L;
    proc_data  = (k < 0) ? 24'd0 : hsv_of(h_rgb[k % 64]);
    proc_de    = (k < 0) ? 1'b0 : h_de[k % 64];
    proc_hsync = (k < 0) ? 1'b0 : h_hs[k % 64];
    proc_vsync = (k < 0) ? 1'b0 : h_vs[k % 64];
    prev_vs = (n > 0) ? h_vs[(n - 1) % 64] : 1'b0;
    fs = in_vsync && !prev_vs;
    e_fd = STATS && fs && running;
    if (STATS && fs && running) begin e_pix = CW'(HACT); e_line = CW'(VACT); end
    if (!running) begin
      if (fs) running = 1;
    end else if (has_pend) begin
      if (fs) begin active = pend_mode; has_pend = 0; end
    end else if (v && r != 2'd3) begin
      has_pend = 1; pend_mode = r;
    end
    h_pm[n % 64] = active;
    @(posedge clk); #1;
    pm = (k < 0) ? 2'd0 : h_pm[k % 64];
    e_de = (k < 0) ? 1'b0 : h_de[k % 64];
    e_hs = (k < 0) ? 1'b0 : h_hs[k % 64];
    e_vs = (k < 0) ? 1'b0 : h_vs[k % 64];
    e_data = (k < 0 || pm == 2'd2) ? 24'd0 : (pm == 2'd1 ? hsv_of(h_rgb[k % 64]) : h_rgb[k % 64]);
    j = n - L + 1;
    e_ready = running && !has_pend;
    e_ce = running || (j >= 0 && h_pm[j % 64] == 2'd1);
    n++; gpos = (gpos + 1) % FRAME;
  endtask

  task automatic test_reset();
    zero_inputs(); model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({out_de, out_hsync, out_vsync, out_data, mode_active, mode_req_ready, conv_ce, frame_done, pix_cnt, line_cnt} !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", {out_de, out_hsync, out_vsync, out_data, mode_active, mode_req_ready, conv_ce}); end
    rst_n = 1'b1;
    gpos = 3 * HT;
    for (int i = 0; i < FRAME + 50; i++) begin
      step(1'b0, 2'd0);
      checks++; if (out_data !== e_data) begin failures++; $display("FAIL reset_data n=%0d got=%h exp=%h", n, out_data, e_data); end
      checks++; if ({out_de, out_hsync, out_vsync} !== {e_de, e_hs, e_vs}) begin failures++; $display("FAIL reset_timing n=%0d got=%b exp=%b", n, {out_de, out_hsync, out_vsync}, {e_de, e_hs, e_vs}); end
      checks++; if ({mode_active, mode_req_ready, conv_ce} !== {active, e_ready, e_ce}) begin failures++; $display("FAIL reset_ctrl n=%0d got=%b exp=%b", n, {mode_active, mode_req_ready, conv_ce}, {active, e_ready, e_ce}); end
    end
    checks++; if (mode_req_ready !== 1'b1) begin failures++; $display("FAIL idle_to_run got=%b exp=1", mode_req_ready); end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 2'd0);
      checks++; if (out_data !== e_data) begin failures++; $display("FAIL bypass_data n=%0d got=%h exp=%h", n, out_data, e_data); end
      checks++; if ({out_de, out_hsync, out_vsync} !== {e_de, e_hs, e_vs}) begin failures++; $display("FAIL bypass_timing n=%0d got=%b exp=%b", n, {out_de, out_hsync, out_vsync}, {e_de, e_hs, e_vs}); end
      checks++; if ({pix_cnt, line_cnt, frame_done} !== {e_pix, e_line, e_fd}) begin failures++; $display("FAIL bypass_stats n=%0d got=%h exp=%h", n, {pix_cnt, line_cnt, frame_done}, {e_pix, e_line, e_fd}); end
    end
  endtask

  task automatic test_hsv_switch();
    for (int i = 0; i < 2 * FRAME && gpos != 3 * HT + 30; i++) step(1'b0, 2'd0);
    checks++; if (mode_req_ready !== 1'b1) begin failures++; $display("FAIL hsv_ready_before got=%b exp=1", mode_req_ready); end
    step(1'b1, 2'd1);
    checks++; if ({mode_req_ready, mode_active} !== {1'b0, 2'd0}) begin failures++; $display("FAIL hsv_accept got=%b exp=000", {mode_req_ready, mode_active}); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 2'd0);
      checks++; if (out_data !== e_data) begin failures++; $display("FAIL hsv_data n=%0d got=%h exp=%h", n, out_data, e_data); end
      checks++; if ({out_de, out_hsync, out_vsync} !== {e_de, e_hs, e_vs}) begin failures++; $display("FAIL hsv_timing n=%0d got=%b exp=%b", n, {out_de, out_hsync, out_vsync}, {e_de, e_hs, e_vs}); end
      checks++; if ({mode_active, mode_req_ready, conv_ce} !== {active, e_ready, e_ce}) begin failures++; $display("FAIL hsv_ctrl n=%0d got=%b exp=%b", n, {mode_active, mode_req_ready, conv_ce}, {active, e_ready, e_ce}); end
    end
    checks++; if (mode_active !== 2'd1) begin failures++; $display("FAIL hsv_applied got=%0d exp=1", mode_active); end
  endtask

  task automatic test_black_at_fs();
    int de_cnt, nz_cnt;
    for (int i = 0; i < 2 * FRAME && gpos != 0; i++) step(1'b0, 2'd0);
    step(1'b1, 2'd2);
    checks++; if ({mode_active, mode_req_ready} !== {2'd1, 1'b0}) begin failures++; $display("FAIL black_at_fs got=%b exp=010", {mode_active, mode_req_ready}); end
    for (int i = 0; i < 2 * FRAME && gpos != 0; i++) begin
      step(1'b0, 2'd0);
      checks++; if ({mode_active, out_data} !== {active, e_data}) begin failures++; $display("FAIL black_wait n=%0d got=%h exp=%h", n, {mode_active, out_data}, {active, e_data}); end
    end
    checks++; if (mode_active !== 2'd1) begin failures++; $display("FAIL black_held got=%0d exp=1", mode_active); end
    step(1'b0, 2'd0);
    checks++; if (mode_active !== 2'd2) begin failures++; $display("FAIL black_applied got=%0d exp=2", mode_active); end
    de_cnt = 0; nz_cnt = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      step(1'b0, 2'd0);
      if (out_de) de_cnt++;
      if (out_de && out_data != 24'd0) nz_cnt++;
      checks++; if ({out_de, out_hsync, out_vsync, out_data} !== {e_de, e_hs, e_vs, e_data}) begin failures++; $display("FAIL black_out n=%0d got=%h exp=%h", n, {out_de, out_hsync, out_vsync, out_data}, {e_de, e_hs, e_vs, e_data}); end
    end
    checks++; if (de_cnt != HACT * VACT || nz_cnt != 0) begin failures++; $display("FAIL black_frame de=%0d nonzero=%0d exp de=%0d nonzero=0", de_cnt, nz_cnt, HACT * VACT); end
  endtask

  task automatic test_reserved();
    for (int i = 0; i < 2 * FRAME && gpos != 4 * HT; i++) step(1'b0, 2'd0);
    step(1'b1, 2'd3);
    checks++; if ({mode_req_ready, mode_active} !== {1'b1, 2'd2}) begin failures++; $display("FAIL reserved got=%b exp=110", {mode_req_ready, mode_active}); end
    for (int i = 0; i < FRAME + 20; i++) begin
      step(1'b0, 2'd0);
      checks++; if ({mode_active, mode_req_ready, out_data} !== {2'd2, 1'b1, e_data}) begin failures++; $display("FAIL reserved_hold n=%0d got=%h exp=%h", n, {mode_active, mode_req_ready, out_data}, {2'd2, 1'b1, e_data}); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FRAME; i++) begin
      step($urandom_range(0, 299) == 0, 2'($urandom_range(0, 3)));
      checks++; if (out_data !== e_data) begin failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, out_data, e_data); end
      checks++; if ({out_de, out_hsync, out_vsync} !== {e_de, e_hs, e_vs}) begin failures++; $display("FAIL rand_timing n=%0d got=%b exp=%b", n, {out_de, out_hsync, out_vsync}, {e_de, e_hs, e_vs}); end
      checks++; if ({mode_active, mode_req_ready, conv_ce} !== {active, e_ready, e_ce}) begin failures++; $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n, {mode_active, mode_req_ready, conv_ce}, {active, e_ready, e_ce}); end
    end
  endtask

  task automatic test_stats();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 2 * FRAME && gpos != 1; i++) step(1'b0, 2'd0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 2'd0);
      if (frame_done) pulses++;
      checks++; if ({pix_cnt, line_cnt, frame_done} !== {e_pix, e_line, e_fd}) begin failures++; $display("FAIL stats n=%0d got=%h exp=%h", n, {pix_cnt, line_cnt, frame_done}, {e_pix, e_line, e_fd}); end
    end
    checks++; if (pulses != (STATS ? 2 : 0)) begin failures++; $display("FAIL stats_pulses got=%0d exp=%0d", pulses, STATS ? 2 : 0); end
    checks++; if ({pix_cnt, line_cnt} !== {CW'(STATS ? HACT : 0), CW'(STATS ? VACT : 0)}) begin failures++; $display("FAIL stats_counts got=%0d/%0d", pix_cnt, line_cnt); end
  endtask

  task automatic test_reset_in_pend();
    for (int i = 0; i < 2 * FRAME && !(e_ready && gpos == 2 * HT); i++) step(1'b0, 2'd0);
    step(1'b1, 2'd1);
    checks++; if (mode_req_ready !== 1'b0) begin failures++; $display("FAIL pend_entry got=%b exp=0", mode_req_ready); end
    @(negedge clk); #2;
    rst_n = 1'b0; zero_inputs();
    #1;
    checks++; if ({out_de, out_hsync, out_vsync, out_data, mode_active, mode_req_ready, conv_ce, frame_done, pix_cnt, line_cnt} !== '0) begin failures++; $display("FAIL pend_reset got=%h exp=0", {out_de, out_hsync, out_vsync, out_data, mode_active, mode_req_ready, conv_ce}); end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 10 && !running; i++) begin
      step(1'b0, 2'd0);
      checks++; if ({mode_active, mode_req_ready, conv_ce, out_data} !== {active, e_ready, e_ce, e_data}) begin failures++; $display("FAIL pend_resume n=%0d got=%h exp=%h", n, {mode_active, mode_req_ready, conv_ce, out_data}, {active, e_ready, e_ce, e_data}); end
    end
    repeat (5) step(1'b0, 2'd0);
    checks++; if ({mode_active, mode_req_ready} !== {2'd0, 1'b1}) begin failures++; $display("FAIL pend_after_reset got=%b exp=001", {mode_active, mode_req_ready}); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_bypass();
    test_hsv_switch();
    test_black_at_fs();
    test_reserved();
    test_random();
    test_stats();
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
